// File: rtl/p4_parser_mx.sv
// p4_parser_mx: table-driven header parser.
// Latches one cell at a time, walks the headers by issuing lookups against the
// bytes at the header pointer, extracts fields into the PHV and emits a single
// PHV per frame. Dropped frames still emit a PHV so that length and error
// information reach the downstream block.
// Optional build macro: P4_PARSER_STATS_EN adds 32-bit outcome counters.
//
// state   | meaning
// IDLE    | waiting for a SOF cell, non-SOF cells are discarded
// LOOKUP  | one-cycle lookup request for the current parse state
// WAIT    | waiting for the lookup response
// FETCH   | header pointer ran past the latched cell, pull in the next one
// PAYLOAD | parse accepted, drain the remaining cells of the frame
// EMIT    | present the PHV until it is taken
// DROP    | frame dropped, drain the remaining cells of the frame
module p4_parser_mx #(
    parameter int         CELL_B        = 64,
    parameter int         PHV_B         = 128,
    parameter int         MAX_STEPS     = 16,
    parameter int         EXTRACT_MAX_B = 4,
    parameter logic [5:0] START_STATE   = 6'd1
) (
    input  logic                  clk_dp,
    input  logic                  rst_dp_n,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [CELL_B*8-1:0]   rx_data,
    input  logic                  rx_sof,
    input  logic                  rx_eof,
    input  logic [6:0]            rx_eop_len,
    input  logic [4:0]            rx_port,
    output logic                  lk_req,
    output logic [5:0]            lk_state,
    output logic [63:0]           lk_window,
    input  logic                  lk_rsp_valid,
    input  logic                  lk_hit,
    input  logic [5:0]            lk_next_state,
    input  logic [7:0]            lk_ext_off,
    input  logic [2:0]            lk_ext_len,
    input  logic [7:0]            lk_phv_dst,
    input  logic [7:0]            lk_hdr_adv,
    output logic                  phv_valid,
    input  logic                  phv_ready,
    output logic [PHV_B*8-1:0]    phv_data,
    output logic [4:0]            phv_port,
    output logic [13:0]           phv_pkt_len,
    output logic                  phv_drop,
    output logic [1:0]            phv_err
`ifdef P4_PARSER_STATS_EN
    ,
    output logic [31:0]           stat_accept,
    output logic [31:0]           stat_drop,
    output logic [31:0]           stat_trunc
`endif
);

    localparam int         SW     = $clog2(MAX_STEPS + 1);
    localparam logic [5:0] ACCEPT = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WAIT, S_FETCH, S_PAYLOAD, S_EMIT, S_DROP
    } state_t;

    state_t              state, state_nxt;
    logic [CELL_B*8-1:0] cell_q;
    logic                cell_eof;
    logic [15:0]         hdr_ptr, cell_base;
    logic [SW-1:0]       step;
    logic [5:0]          pstate;
    logic [PHV_B*8-1:0]  phv_q, phv_upd;
    logic [4:0]          port_q;
    logic [13:0]         len_q;
    logic                drop_q;
    logic [1:0]          err_q;

    logic                ld_first, ld_next, hit_upd, add_len, set_drop;
    logic [1:0]          drop_code;

    logic [15:0]         off, new_ptr, fetch_base, next_end;
    logic [SW-1:0]       new_step;
    logic [6:0]          cell_len;
    logic [14:0]         len_sum;
    logic [13:0]         len_add;

    // out-of-cell source bytes read as zero
    function automatic logic [7:0] get_byte(input logic [CELL_B*8-1:0] c, input int idx);
        if (idx >= 0 && idx < CELL_B) return c[idx*8 +: 8];
        return 8'h00;
    endfunction

    assign off        = hdr_ptr - cell_base;
    assign new_ptr    = hdr_ptr + {8'h00, lk_hdr_adv};
    assign new_step   = step + SW'(1);
    assign fetch_base = cell_base + 16'(CELL_B);
    assign next_end   = fetch_base + 16'(CELL_B);
    assign cell_len   = rx_eof ? rx_eop_len : 7'(CELL_B);
    assign len_sum    = {1'b0, len_q} + {8'h00, cell_len};
    assign len_add    = len_sum[14] ? 14'h3FFF : len_sum[13:0];

    assign lk_state    = pstate;
    assign phv_data    = phv_q;
    assign phv_port    = port_q;
    assign phv_pkt_len = len_q;
    assign phv_drop    = drop_q;
    assign phv_err     = err_q;

    // eight-byte lookup key window at the header pointer
    always_comb begin
        lk_window = '0;
        for (int i = 0; i < 8; i++)
            lk_window[i*8 +: 8] = get_byte(cell_q, int'(off) + i);
    end

    // PHV image after applying the current lookup's extract
    always_comb begin
        phv_upd = phv_q;
        for (int k = 0; k < EXTRACT_MAX_B; k++) begin
            if (k < int'(lk_ext_len) && (int'(lk_phv_dst) + k) < PHV_B)
                phv_upd[(int'(lk_phv_dst) + k)*8 +: 8] =
                    get_byte(cell_q, int'(off) + int'(lk_ext_off) + k);
        end
    end

    // state register
    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // next state, handshakes and datapath strobes
    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        lk_req    = 1'b0;
        phv_valid = 1'b0;
        ld_first  = 1'b0;
        ld_next   = 1'b0;
        hit_upd   = 1'b0;
        add_len   = 1'b0;
        set_drop  = 1'b0;
        drop_code = 2'd0;
        unique case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid && rx_sof) begin
                    ld_first  = 1'b1;
                    state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lk_req    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (lk_rsp_valid) begin
                    if (!lk_hit) begin
                        set_drop  = 1'b1;
                        drop_code = 2'd1;
                    end else begin
                        hit_upd = 1'b1;
                        if (lk_next_state == ACCEPT) begin
                            state_nxt = cell_eof ? S_EMIT : S_PAYLOAD;
                        end else if (new_step == SW'(MAX_STEPS)) begin
                            set_drop  = 1'b1;
                            drop_code = 2'd2;
                        end else if (new_ptr >= fetch_base) begin
                            // no further cell can follow an EOF cell
                            if (cell_eof) begin
                                set_drop  = 1'b1;
                                drop_code = 2'd3;
                            end else begin
                                state_nxt = S_FETCH;
                            end
                        end else begin
                            state_nxt = S_LOOKUP;
                        end
                    end
                    if (set_drop) state_nxt = cell_eof ? S_EMIT : S_DROP;
                end
            end
            S_FETCH: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    ld_next = 1'b1;
                    add_len = 1'b1;
                    if (hdr_ptr >= next_end) begin
                        if (rx_eof) begin
                            set_drop  = 1'b1;
                            drop_code = 2'd3;
                            state_nxt = S_EMIT;
                        end else begin
                            state_nxt = S_FETCH;
                        end
                    end else begin
                        state_nxt = S_LOOKUP;
                    end
                end
            end
            S_PAYLOAD, S_DROP: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    add_len = 1'b1;
                    if (rx_eof) state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                phv_valid = 1'b1;
                if (phv_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // frame context, parse pointers and PHV contents
    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            cell_q    <= '0;
            cell_eof  <= 1'b0;
            hdr_ptr   <= '0;
            cell_base <= '0;
            step      <= '0;
            pstate    <= '0;
            phv_q     <= '0;
            port_q    <= '0;
            len_q     <= '0;
            drop_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            if (ld_first) begin
                cell_q    <= rx_data;
                cell_eof  <= rx_eof;
                hdr_ptr   <= '0;
                cell_base <= '0;
                step      <= '0;
                pstate    <= START_STATE;
                phv_q     <= '0;
                port_q    <= rx_port;
                len_q     <= {7'd0, cell_len};
                drop_q    <= 1'b0;
                err_q     <= '0;
            end
            if (ld_next) begin
                cell_q    <= rx_data;
                cell_eof  <= rx_eof;
                cell_base <= fetch_base;
            end
            if (add_len) len_q <= len_add;
            if (hit_upd) begin
                phv_q   <= phv_upd;
                hdr_ptr <= new_ptr;
                step    <= new_step;
                pstate  <= lk_next_state;
            end
            if (set_drop) begin
                drop_q <= 1'b1;
                err_q  <= drop_code;
            end
        end
    end

`ifdef P4_PARSER_STATS_EN
    // outcome counters; stat_drop counts every drop, stat_trunc the truncated subset
    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            stat_accept <= '0;
            stat_drop   <= '0;
            stat_trunc  <= '0;
        end else if (state == S_EMIT && phv_ready) begin
            if (!drop_q) stat_accept <= stat_accept + 32'd1;
            else         stat_drop   <= stat_drop + 32'd1;
            if (drop_q && err_q == 2'd3) stat_trunc <= stat_trunc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_p4_parser_mx.sv
// Directed bench for p4_parser_mx with hand-computed expectations.
module tb_p4_parser_mx;

    logic          clk_dp = 1'b0;
    logic          rst_dp_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [511:0]  rx_data = '0;
    logic          rx_sof = 1'b0, rx_eof = 1'b0;
    logic [6:0]    rx_eop_len = '0;
    logic [4:0]    rx_port = '0;
    logic          lk_req;
    logic [5:0]    lk_state;
    logic [63:0]   lk_window;
    logic          lk_rsp_valid = 1'b0, lk_hit = 1'b0;
    logic [5:0]    lk_next_state = '0;
    logic [7:0]    lk_ext_off = '0;
    logic [2:0]    lk_ext_len = '0;
    logic [7:0]    lk_phv_dst = '0, lk_hdr_adv = '0;
    logic          phv_valid, phv_ready = 1'b0;
    logic [1023:0] phv_data;
    logic [4:0]    phv_port;
    logic [13:0]   phv_pkt_len;
    logic          phv_drop;
    logic [1:0]    phv_err;
`ifdef P4_PARSER_STATS_EN
    logic [31:0]   stat_accept, stat_drop, stat_trunc;
`endif

    int ntotal = 0, npass = 0, nfail = 0;
    int req_cnt = 0;

    p4_parser_mx dut (
        .clk_dp(clk_dp), .rst_dp_n(rst_dp_n),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_eop_len(rx_eop_len), .rx_port(rx_port),
        .lk_req(lk_req), .lk_state(lk_state), .lk_window(lk_window),
        .lk_rsp_valid(lk_rsp_valid), .lk_hit(lk_hit), .lk_next_state(lk_next_state),
        .lk_ext_off(lk_ext_off), .lk_ext_len(lk_ext_len), .lk_phv_dst(lk_phv_dst),
        .lk_hdr_adv(lk_hdr_adv),
        .phv_valid(phv_valid), .phv_ready(phv_ready), .phv_data(phv_data),
        .phv_port(phv_port), .phv_pkt_len(phv_pkt_len), .phv_drop(phv_drop),
        .phv_err(phv_err)
`ifdef P4_PARSER_STATS_EN
        ,
        .stat_accept(stat_accept), .stat_drop(stat_drop), .stat_trunc(stat_trunc)
`endif
    );

    always #5 clk_dp = ~clk_dp;

    // count lookup request cycles mid-cycle
    always @(negedge clk_dp) if (lk_req === 1'b1) req_cnt++;

    task automatic tick();
        @(posedge clk_dp);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_cell(input logic [7:0] b);
        logic [511:0] c;
        for (int i = 0; i < 64; i++) c[i*8 +: 8] = b + 8'(i);
        return c;
    endfunction

    task automatic send_cell(input logic [511:0] d, input logic sof, input logic eof,
                             input logic [6:0] eop, input logic [4:0] port);
        bit done = 0;
        rx_valid = 1'b1; rx_data = d; rx_sof = sof; rx_eof = eof;
        rx_eop_len = eop; rx_port = port;
        for (int n = 0; n < 50 && !done; n++) begin
            if (rx_ready === 1'b1) done = 1;
            tick();
        end
        if (!done) chk("send_timeout", 0, 1);
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    endtask

    task automatic lookup(input logic hit, input logic [5:0] nxt, input logic [7:0] eoff,
                          input logic [2:0] elen, input logic [7:0] dst, input logic [7:0] adv);
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (lk_req === 1'b1) seen = 1;
            else tick();
        end
        if (!seen) chk("lk_req_timeout", 0, 1);
        tick();
        lk_rsp_valid = 1'b1; lk_hit = hit; lk_next_state = nxt; lk_ext_off = eoff;
        lk_ext_len = elen; lk_phv_dst = dst; lk_hdr_adv = adv;
        tick();
        lk_rsp_valid = 1'b0; lk_hit = 1'b0;
    endtask

    task automatic wait_phv();
        bit seen = 0;
        for (int n = 0; n < 400 && !seen; n++) begin
            if (phv_valid === 1'b1) seen = 1;
            else tick();
        end
        if (!seen) chk("phv_timeout", 0, 1);
    endtask

    task automatic take_phv();
        phv_ready = 1'b1;
        tick();
        phv_ready = 1'b0;
    endtask

    initial begin
        logic [1023:0] exp;
        int r0;
`ifdef P4_PARSER_STATS_EN
        logic [31:0] sa0;
`endif
        // reset state
        tick(); tick();
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_phv_valid", phv_valid, 0);
        chk("rst_lk_req", lk_req, 0);
        chk("rst_pkt_len", phv_pkt_len, 0);
        chk("rst_lk_state", lk_state, 0);
        rst_dp_n = 1'b1;
        tick();

        // non-SOF cell in IDLE is swallowed
        send_cell(mk_cell(8'hA0), 0, 1, 7'd30, 5'd1);
        tick();
        chk("nosof_lk_req", lk_req, 0);
        chk("nosof_rx_ready", rx_ready, 1);

        // single 60B cell, accept on first lookup
        send_cell(mk_cell(8'h00), 1, 1, 7'd60, 5'd5);
        chk("t1_lk_req", lk_req, 1);
        chk("t1_lk_state", lk_state, 6'd1);
        chk("t1_window", lk_window, 64'h0706050403020100);
        chk("t1_rx_ready_lookup", rx_ready, 0);
        lookup(1, 6'h3F, 8'd12, 3'd2, 8'd0, 8'd14);
        wait_phv();
        chk("t1_phv16", phv_data[15:0], 16'h0D0C);
        chk("t1_phv", phv_data, 1024'h0D0C);
        chk("t1_len", phv_pkt_len, 14'd60);
        chk("t1_drop", phv_drop, 0);
        chk("t1_err", phv_err, 0);
        chk("t1_port", phv_port, 5'd5);
`ifdef P4_PARSER_STATS_EN
        sa0 = stat_accept;
`endif
        // back-pressure on the PHV for 10 cycles
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("hold_valid", phv_valid, 1);
            chk("hold_data", phv_data, 1024'h0D0C);
            chk("hold_rx_ready", rx_ready, 0);
        end
        take_phv();
        chk("t1_after_valid", phv_valid, 0);
        chk("t1_after_rx_ready", rx_ready, 1);
`ifdef P4_PARSER_STATS_EN
        chk("stat_accept_inc", stat_accept, sa0 + 32'd1);
`endif

        // three-cell frame with fetch and payload
        send_cell(mk_cell(8'h40), 1, 0, 7'd0, 5'd7);
        chk("t2_window0", lk_window, 64'h4746454443424140);
        lookup(1, 6'd2, 8'd0, 3'd1, 8'd10, 8'd70);
        chk("t2_fetch_rx_ready", rx_ready, 1);
        send_cell(mk_cell(8'h80), 0, 0, 7'd0, 5'd7);
        chk("t2_lk_req2", lk_req, 1);
        chk("t2_window1", lk_window, 64'h8D8C8B8A89888786);
        chk("t2_lk_state", lk_state, 6'd2);
        lookup(1, 6'h3F, 8'd1, 3'd7, 8'd20, 8'd0);
        chk("t2_payload_rx_ready", rx_ready, 1);
        send_cell(mk_cell(8'hC0), 0, 1, 7'd10, 5'd7);
        wait_phv();
        exp = '0;
        exp[10*8 +: 8] = 8'h40;
        exp[20*8 +: 8] = 8'h87;
        exp[21*8 +: 8] = 8'h88;
        exp[22*8 +: 8] = 8'h89;
        exp[23*8 +: 8] = 8'h8A;
        chk("t2_phv", phv_data, exp);
        chk("t2_len", phv_pkt_len, 14'd138);
        chk("t2_drop", phv_drop, 0);
        take_phv();

        // miss on a 2-cell frame
        send_cell(mk_cell(8'h11), 1, 0, 7'd0, 5'd2);
        lookup(0, 6'd0, 8'd0, 3'd0, 8'd0, 8'd0);
        chk("t3_drop_rx_ready", rx_ready, 1);
        send_cell(mk_cell(8'h22), 0, 1, 7'd5, 5'd2);
        wait_phv();
        chk("t3_drop", phv_drop, 1);
        chk("t3_err", phv_err, 2'd1);
        chk("t3_len", phv_pkt_len, 14'd69);
        chk("t3_phv", phv_data, 0);
        take_phv();

        // self-looping lookup runs out of steps
        r0 = req_cnt;
        send_cell(mk_cell(8'h33), 1, 1, 7'd20, 5'd3);
        for (int n = 0; n < 16; n++) lookup(1, 6'd1, 8'd0, 3'd0, 8'd0, 8'd0);
        wait_phv();
        tick();
        chk("t4_req_count", req_cnt - r0, 16);
        chk("t4_drop", phv_drop, 1);
        chk("t4_err", phv_err, 2'd2);
        chk("t4_phv_empty", phv_data, 0);
        take_phv();

        // advance past a lone EOF cell is truncation, no fetch
        send_cell(mk_cell(8'h44), 1, 1, 7'd64, 5'd4);
        lookup(1, 6'd2, 8'd0, 3'd0, 8'd0, 8'd64);
        chk("t5_direct_emit", phv_valid, 1);
        chk("t5_rx_ready", rx_ready, 0);
        chk("t5_drop", phv_drop, 1);
        chk("t5_err", phv_err, 2'd3);
        chk("t5_len", phv_pkt_len, 14'd64);
        take_phv();

        // extraction reaching past the cell end and past the PHV end
        send_cell(mk_cell(8'h10), 1, 1, 7'd64, 5'd6);
        lookup(1, 6'd4, 8'd0, 3'd0, 8'd0, 8'd60);
        chk("t6_lk_state", lk_state, 6'd4);
        chk("t6_window_edge", lk_window, 64'h000000004F4E4D4C);
        lookup(1, 6'h3F, 8'd2, 3'd4, 8'd126, 8'd0);
        wait_phv();
        exp = '0;
        exp[126*8 +: 8] = 8'h4E;
        exp[127*8 +: 8] = 8'h4F;
        chk("t6_phv_edge", phv_data, exp);
        chk("t6_err", phv_err, 0);
        take_phv();

        // length saturation over a long dropped frame
        send_cell(mk_cell(8'h55), 1, 0, 7'd0, 5'd8);
        lookup(0, 6'd0, 8'd0, 3'd0, 8'd0, 8'd0);
        for (int n = 0; n < 299; n++) send_cell(mk_cell(8'h66), 0, 0, 7'd0, 5'd8);
        send_cell(mk_cell(8'h77), 0, 1, 7'd64, 5'd8);
        wait_phv();
        chk("t7_len_sat", phv_pkt_len, 14'd16383);
        chk("t7_err", phv_err, 2'd1);
        take_phv();

        // reset mid-frame abandons it
        send_cell(mk_cell(8'h99), 1, 0, 7'd0, 5'd9);
        rst_dp_n = 1'b0;
        #1;
        chk("t8_rst_rx_ready", rx_ready, 1);
        chk("t8_rst_lk_req", lk_req, 0);
        tick();
        rst_dp_n = 1'b1;
        r0 = req_cnt;
        for (int n = 0; n < 5; n++) tick();
        chk("t8_no_phv", phv_valid, 0);
        chk("t8_no_req", req_cnt - r0, 0);
        chk("t8_len_zero", phv_pkt_len, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/p4_parser_mx.md
P4_PARSER_MX -- requirements
Module: p4_parser_mx

Interface
REQ-001 SHALL have parameters: CELL_B, default 64, cell width in bytes; PHV_B, default 128, PHV width in bytes; MAX_STEPS, default 16, maximum lookups per frame; EXTRACT_MAX_B, default 4, maximum bytes per extract; START_STATE, default 6'd1, initial parse state.
REQ-002 SHALL have ports:
- clk_dp  in  1  datapath clock.
- rst_dp_n  in  1  asynchronous active-low reset.
- rx_valid / rx_ready  in / out  1 / 1  cell handshake.
- rx_data  in  CELL_B*8  cell data; byte 0 is in bits [7:0].
- rx_sof, rx_eof  in  1 each  frame start and frame end.
- rx_eop_len  in  7  valid bytes in an EOF cell, range 1..64.
- rx_port  in  5  ingress port.
- lk_req  out  1  lookup request.
- lk_state  out  6  current parse state.
- lk_window  out  64  8 bytes at the header pointer.
- lk_rsp_valid  in  1  lookup response strobe.
- lk_hit  in  1  lookup hit.
- lk_next_state  in  6  next parse state.
- lk_ext_off  in  8  extract offset in bytes.
- lk_ext_len  in  3  extract length in bytes.
- lk_phv_dst  in  8  PHV destination byte.
- lk_hdr_adv  in  8  header pointer advance in bytes.
- phv_valid / phv_ready  out / in  1 / 1  PHV handshake.
- phv_data  out  PHV_B*8  extracted fields.
- phv_port  out  5  ingress port.
- phv_pkt_len  out  14  frame length in bytes.
- phv_drop  out  1  frame is dropped.
- phv_err  out  2  error code.

Function
REQ-003 SHALL implement states IDLE, LOOKUP, WAIT, FETCH, PAYLOAD, EMIT, DROP.
REQ-004 In IDLE, rx_ready SHALL be 1 and rx_valid&rx_sof SHALL: latch the cell; clear phv_data; set hdr_ptr=0, cell_base=0, step=0, parse state=START_STATE; then go to LOOKUP.
REQ-005 In IDLE, cells arriving without SOF SHALL be consumed and discarded.
REQ-006 lk_req SHALL be high for exactly one cycle, in LOOKUP.
REQ-007 lk_window byte i SHALL equal latched byte (hdr_ptr-cell_base+i), or zero when that index is >= CELL_B.
REQ-008 WAIT SHALL hold until lk_rsp_valid, with no timeout, and SHALL ignore lk_rsp_valid in every other state.
REQ-009 On a hit, PHV byte (lk_phv_dst+k) SHALL receive latched byte (hdr_ptr-cell_base+lk_ext_off+k) for k < min(lk_ext_len, EXTRACT_MAX_B).
REQ-010 On a hit, source bytes past the cell end SHALL read as zero, and destination bytes >= PHV_B SHALL be discarded.
REQ-011 lk_ext_len=0 SHALL extract nothing.
REQ-012 On a hit, hdr_ptr SHALL advance by lk_hdr_adv, step SHALL increment, and parse state SHALL become lk_next_state.
REQ-013 After a hit, lk_next_state==6'h3F (ACCEPT) SHALL go to EMIT if the current cell is EOF, else to PAYLOAD.
REQ-014 After a non-ACCEPT hit, the block SHALL go to FETCH if the new hdr_ptr >= cell_base+CELL_B, else to LOOKUP.
REQ-015 FETCH SHALL assert rx_ready, accept the next cell, set cell_base+=CELL_B, and then re-check REQ-014.
REQ-016 A FETCH needed while the current cell is EOF SHALL drop the frame with err=3 (truncated).
REQ-017 A miss SHALL drop the frame with err=1.
REQ-018 A hit that makes step reach MAX_STEPS without ACCEPT SHALL drop the frame with err=2.
REQ-019 A drop SHALL set phv_drop=1 and go to EMIT if the current cell is EOF, else to DROP.
REQ-020 PAYLOAD and DROP SHALL consume cells with rx_ready=1 and go to EMIT after the EOF cell.
REQ-021 pkt_len SHALL add 64 per non-EOF cell and rx_eop_len for the EOF cell, over every cell of the frame, and SHALL saturate at 16383.
REQ-022 EMIT SHALL hold phv_valid with stable outputs until phv_ready, then go to IDLE.
REQ-023 rx_ready SHALL be 0 in LOOKUP, WAIT and EMIT.
REQ-024 A dropped frame SHALL still emit a PHV, with drop=1, err set and pkt_len valid.
REQ-025 err SHALL be 0 on accept.

Reset
REQ-026 Reset SHALL force IDLE and zero all counters, pointers and outputs, with phv_valid=0, lk_req=0 and rx_ready=1.
REQ-027 Reset mid-frame SHALL abandon the frame without emitting a PHV.

Configuration
REQ-028 With P4_PARSER_STATS_EN defined, the block SHALL add outputs stat_accept, stat_drop and stat_trunc, each 32-bit.
REQ-029 Each stat counter SHALL increment on an EMIT handshake of the matching outcome, SHALL wrap at 2^32, and SHALL reset to 0.
REQ-030 With P4_PARSER_STATS_EN undefined, those ports and their logic SHALL be absent.

Verification
REQ-031 Single 60B cell, ACCEPT hit on first lookup with ext_off=12, len=2, dst=0 -> phv_data[15:0]={byte13,byte12}, pkt_len=60, drop=0.
REQ-032 Three-cell frame, first lookup adv=70 -> FETCH consumes cell 2, lookup at byte 6 of cell 2, then ACCEPT -> PAYLOAD consumes cell 3, pkt_len=64+64+eop_len.
REQ-033 Miss on first lookup of a 2-cell frame -> DROP consumes cell 2, then PHV with drop=1, err=1.
REQ-034 Self-looping hit with MAX_STEPS=16 -> exactly 16 lk_req pulses, then err=2.
REQ-035 Single EOF cell, adv=64 without ACCEPT -> err=3, with no rx_ready in FETCH.
REQ-036 phv_ready held low for 10 cycles -> phv_valid and data stable, rx_ready=0 throughout, and with P4_PARSER_STATS_EN defined stat_accept increments by exactly 1.
